ctrl_frame_tx: RTL and testbench
================================

# ctrl_frame_tx

Serial frame transmitter for the analog control interface. Accepts one parallel word each of VREF, DATA, CONVER and COMP settings and drives four one-bit serial lines. Each line carries a leading-marker frame that the on-chip control receiver's marker-terminated shift registers capture, then freeze on. Sits on the digital side, for example behind the SPI/test controller, and drives `in_vref`, `in_data`, `in_conver` and `in_comp` of the control receiver on the same clock.

## Interface

Parameters:
- `VREF_W`, default 4: VREF field width.
- `DATA_W`, default 8: DATA field width.
- `CONVER_W`, default 8: CONVER field width.
- `COMP_W`, default 6: COMP field width.
- `FRAME_LEN`, derived, equals max(field widths) + 1 (9 by default). Not overridable.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: a parallel word is offered.
- `in_ready`, output, 1: the block accepts a word this cycle.
- `vref`, input, `VREF_W`: VREF field, sampled on acceptance.
- `data`, input, `DATA_W`: DATA field, sampled on acceptance.
- `conver`, input, `CONVER_W`: CONVER field, sampled on acceptance.
- `comp`, input, `COMP_W`: COMP field, sampled on acceptance.
- `out_vref`, output, 1: VREF serial line.
- `out_data`, output, 1: DATA serial line.
- `out_conver`, output, 1: CONVER serial line.
- `out_comp`, output, 1: COMP serial line.
- `busy`, output, 1: a frame is in flight.
- `done`, output, 1: one-cycle pulse when a frame completes.

## Operation

- States:
  - IDLE: `in_ready`=1, lines=0.
  - SEND: slot counter runs 0..FRAME_LEN-1.
  - LOCK: only exists with the Configuration macro.
- Acceptance: `in_valid && in_ready` on an edge.
  - All four fields are snapshotted into per-line shift registers.
  - State goes to SEND with slot=0.
  - Input changes after acceptance have no effect.
- Line encoding for a field of width W, frame slot s = 0..FRAME_LEN-1:
  - s < FRAME_LEN-1-W: pad bit 0.
  - s = FRAME_LEN-1-W: marker 1.
  - s = FRAME_LEN-W+j: field[j], LSB first.
- Every line therefore ends on the same slot.
  - The receiver's marker reaches its LSB exactly on the last slot, so the captured value equals the field.
  - Pad zeros shift out of the receiver before the marker arrives and are harmless.
- No stall: one bit per clock, because the receiver shifts every clock while armed.
- After slot FRAME_LEN-1 the block returns to IDLE and pulses `done`. Lines return to 0.
- `in_valid` while busy is ignored. It is not queued.
- `busy` = (state==SEND).

## Timing

- Reset values: all lines 0, `busy`=0, `done`=0. `in_ready`=1 after reset release.
- Acceptance edge k → slot s is driven during cycle k+1+s. Lines are registered outputs with no combinational path from the inputs.
- SEND lasts exactly FRAME_LEN cycles (9 by default).
- `done`=1 during cycle k+1+FRAME_LEN. `in_ready` is also 1 in that cycle, so back-to-back frames are possible with no gap.
- Reset asserted mid-frame:
  - All lines go to 0 immediately.
  - State goes to IDLE.
  - No `done` pulse.
  - The frame is abandoned. The receiver must be reset too.
- `in_valid` held high in the same cycle as `done`: the new word is accepted on that edge.

## Configuration

- `CTRL_TX_ONESHOT_EN`:
  - Defined: after the first `done`, the state goes to LOCK. In LOCK, `in_ready`=0 and lines=0 until `rst`. This mirrors the receiver, which freezes after one frame per reset.
  - Undefined: the block returns to IDLE and accepts unlimited frames.

## Structure

- Package `ctrl_frame_pkg` holds:
  - the field-width constants 4/8/8/6;
  - `FRAME_LEN`;
  - the state enum IDLE/SEND/LOCK;
  - a function that builds a FRAME_LEN-bit line vector from a field and its width.
- Sub-module `ctrl_line_ser` (parameter W): a FRAME_LEN-bit load/shift-right register.
  - Drives bit 0 to the line.
  - Shifts in 0.
  - Is instantiated four times.
- The top level holds the FSM, the slot counter and the handshake.

## Test plan

- Basic frame: accept vref=4'hA, data=8'hC3, conver=8'h5A, comp=6'h2D. Required line sequences, slots 0..8:
  - `out_vref`: 0,0,0,0,1,0,1,0,1
  - `out_data`: 1,1,1,0,0,0,0,1,1
  - `out_conver`: 1,0,1,0,1,1,0,1,0
  - `out_comp`: 0,0,1,1,0,1,1,0,1
  - `done` at k+10.
- Receiver loopback: drive the control receiver model from the four lines. After 9 slots, its captured fields equal A/C3/5A/2D with all stop bits=1. Fields stay unchanged for 20 further cycles.
- Busy rejection: pulse `in_valid` with data=8'hFF at slot 4. The frame in flight is unchanged, `in_ready`=0 during SEND, and no second frame is sent.
- Back-to-back (macro undefined): hold `in_valid`=1 with two words. The second frame's slot 0 appears in the cycle after `done`, and there are exactly 18 active slots.
- Reset mid-frame: assert `rst` at slot 5. Lines go to 0 the same cycle, with no `done`. After release, `in_ready`=1.
- One-shot (macro defined): a second `in_valid` after `done` is refused with `in_ready`=0 and lines held at 0. After `rst`, a frame is accepted again.

Source files
------------

// File: rtl/ctrl_frame_pkg.sv
// Shared constants, state encoding and line-vector builder for the control frame transmitter.
package ctrl_frame_pkg;

  localparam int VREF_W_DEF   = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int CONVER_W_DEF = 8;
  localparam int COMP_W_DEF   = 6;

  // Widest line vector the builder can produce.
  localparam int LINE_MAX = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int FRAME_LEN =
    max_int(max_int(VREF_W_DEF, DATA_W_DEF), max_int(CONVER_W_DEF, COMP_W_DEF)) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  // Bit s of the result is the line value in frame slot s: pad zeros, then the
  // marker, then the field LSB first, so every line ends on slot flen-1.
  function automatic logic [LINE_MAX-1:0] build_line(
    input logic [LINE_MAX-1:0] field,
    input int                  w,
    input int                  flen
  );
    logic [LINE_MAX-1:0] mask;
    mask = (LINE_MAX'(1) << w) - LINE_MAX'(1);
    return (((field & mask) << 1) | LINE_MAX'(1)) << (flen - 1 - w);
  endfunction

endpackage

// File: rtl/ctrl_line_ser.sv
// One serial line: load a whole frame vector, then shift it out LSB first.
module ctrl_line_ser
  import ctrl_frame_pkg::*;
#(
  parameter int W   = 8,
  parameter int LEN = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] field,
  output logic         line
);

  typedef logic [LEN-1:0] frame_t;

  frame_t sr;

  // Zeros shifted in leave the register empty once the frame is out, so the
  // line idles low without extra gating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= frame_t'(build_line({{(LINE_MAX-W){1'b0}}, field}, W, LEN));
    end else if (shift) begin
      sr <= {1'b0, sr[LEN-1:1]};
    end
  end

  assign line = sr[0];

endmodule

// File: rtl/ctrl_frame_tx.sv
// Four-line marker-framed serial transmitter for the analog control receiver.
// Optional one-shot lock after the first frame: define CTRL_TX_ONESHOT_EN.
module ctrl_frame_tx
  import ctrl_frame_pkg::*;
#(
  parameter int VREF_W   = VREF_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CONVER_W = CONVER_W_DEF,
  parameter int COMP_W   = COMP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VREF_W-1:0]   vref,
  input  logic [DATA_W-1:0]   data,
  input  logic [CONVER_W-1:0] conver,
  input  logic [COMP_W-1:0]   comp,
  output logic                out_vref,
  output logic                out_data,
  output logic                out_conver,
  output logic                out_comp,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int FRAME_SLOTS =
    max_int(max_int(VREF_W, DATA_W), max_int(CONVER_W, COMP_W)) + 1;
  localparam int SLOT_W = $clog2(FRAME_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] SEND = 2'(ST_SEND);
`ifdef CTRL_TX_ONESHOT_EN
  localparam logic [1:0] LOCK = 2'(ST_LOCK);
`endif

  logic [1:0]        state;
  logic [SLOT_W-1:0] slot;
  logic              accept;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on state, never on in_valid.
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == SEND);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      slot  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SEND;
            slot  <= '0;
          end
        end
        SEND: begin
          if (slot == LAST_SLOT) begin
            done  <= 1'b1;
            slot  <= '0;
`ifdef CTRL_TX_ONESHOT_EN
            state <= LOCK;
`else
            state <= IDLE;
`endif
          end else begin
            slot <= slot + 1'b1;
          end
        end
`ifdef CTRL_TX_ONESHOT_EN
        LOCK: state <= LOCK;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  ctrl_line_ser #(.W(VREF_W), .LEN(FRAME_SLOTS)) u_ser_vref (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (busy),
    .field (vref),
    .line  (out_vref)
  );

  ctrl_line_ser #(.W(DATA_W), .LEN(FRAME_SLOTS)) u_ser_data (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (busy),
    .field (data),
    .line  (out_data)
  );

  ctrl_line_ser #(.W(CONVER_W), .LEN(FRAME_SLOTS)) u_ser_conver (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (busy),
    .field (conver),
    .line  (out_conver)
  );

  ctrl_line_ser #(.W(COMP_W), .LEN(FRAME_SLOTS)) u_ser_comp (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (busy),
    .field (comp),
    .line  (out_comp)
  );

endmodule

// File: tb/tb_ctrl_frame_tx.sv
// Directed bench for ctrl_frame_tx with a marker-terminated receiver model on the lines.
module tb_ctrl_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] vref = '0;
  logic [7:0] data = '0;
  logic [7:0] conver = '0;
  logic [5:0] comp = '0;
  logic       out_vref, out_data, out_conver, out_comp;
  logic       busy, done;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

`ifdef CTRL_TX_ONESHOT_EN
  localparam logic READY_AT_DONE = 1'b0;
`else
  localparam logic READY_AT_DONE = 1'b1;
`endif

  typedef struct {
    logic [3:0] vref;
    logic [7:0] data;
    logic [7:0] conver;
    logic [5:0] comp;
    logic [8:0] ev;   // bit s = expected line value in slot s
    logic [8:0] ed;
    logic [8:0] ec;
    logic [8:0] ep;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  ctrl_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vref       (vref),
    .data       (data),
    .conver     (conver),
    .comp       (comp),
    .out_vref   (out_vref),
    .out_data   (out_data),
    .out_conver (out_conver),
    .out_comp   (out_comp),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Receiver model: shift in at the MSB every clock until a 1 reaches bit 0.
  logic       rx_clr = 1'b0;
  logic [4:0] rx_vref = '0;
  logic [8:0] rx_data = '0;
  logic [8:0] rx_conver = '0;
  logic [6:0] rx_comp = '0;

  always @(posedge clk) begin
    if (rx_clr) begin
      rx_vref   <= '0;
      rx_data   <= '0;
      rx_conver <= '0;
      rx_comp   <= '0;
    end else begin
      if (!rx_vref[0])   rx_vref   <= {out_vref, rx_vref[4:1]};
      if (!rx_data[0])   rx_data   <= {out_data, rx_data[8:1]};
      if (!rx_conver[0]) rx_conver <= {out_conver, rx_conver[8:1]};
      if (!rx_comp[0])   rx_comp   <= {out_comp, rx_comp[6:1]};
    end
  end

  logic cnt_en = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) if (cnt_en && busy) busy_cnt++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic rx_clear();
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
  endtask

  // Offer word i at a negedge; returns at the negedge of slot 0.
  task automatic start_frame(input int i, input bit hold);
    vref = tbl[i].vref; data = tbl[i].data;
    conver = tbl[i].conver; comp = tbl[i].comp;
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    vref = 4'($urandom_range(0, 15));
    data = 8'($urandom_range(0, 255));
    conver = 8'($urandom_range(0, 255));
    comp = 6'($urandom_range(0, 63));
  endtask

  // Checks slots 0..8 and the done cycle; optionally pokes in_valid at one slot.
  task automatic check_frame(input int i, input int poke, input string tag);
    for (int s = 0; s < 9; s++) begin
      chk($sformatf("%s lines s%0d", tag, s),
          {out_vref, out_data, out_conver, out_comp},
          {tbl[i].ev[s], tbl[i].ed[s], tbl[i].ec[s], tbl[i].ep[s]});
      chk($sformatf("%s busy s%0d", tag, s), busy, 1'b1);
      chk($sformatf("%s ready s%0d", tag, s), in_ready, 1'b0);
      chk($sformatf("%s done s%0d", tag, s), done, 1'b0);
      if (s == poke) begin
        in_valid = 1'b1;
        data = 8'hFF;
      end
      @(negedge clk);
      if (s == poke) in_valid = 1'b0;
    end
    chk({tag, " done pulse"}, done, 1'b1);
    chk({tag, " busy at done"}, busy, 1'b0);
    chk({tag, " ready at done"}, in_ready, READY_AT_DONE);
    chk({tag, " lines at done"}, {out_vref, out_data, out_conver, out_comp}, 4'h0);
  endtask

  task automatic check_rx(input int i, input string tag);
    chk({tag, " rx vref"},   rx_vref,   {tbl[i].vref, 1'b1});
    chk({tag, " rx data"},   rx_data,   {tbl[i].data, 1'b1});
    chk({tag, " rx conver"}, rx_conver, {tbl[i].conver, 1'b1});
    chk({tag, " rx comp"},   rx_comp,   {tbl[i].comp, 1'b1});
  endtask

  initial begin
    tbl[0] = '{4'hA, 8'hC3, 8'h5A, 6'h2D, 9'b101010000, 9'b110000111, 9'b010110101, 9'b101101100};
    tbl[1] = '{4'h0, 8'h00, 8'h00, 6'h00, 9'b000010000, 9'b000000001, 9'b000000001, 9'b000000100};
    tbl[2] = '{4'hF, 8'hFF, 8'hFF, 6'h3F, 9'b111110000, 9'b111111111, 9'b111111111, 9'b111111100};
    tbl[3] = '{4'h1, 8'h80, 8'h01, 6'h20, 9'b000110000, 9'b100000001, 9'b000000011, 9'b100000100};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst lines", {out_vref, out_data, out_conver, out_comp}, 4'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst ready", in_ready, 1'b1);
    chk("post-rst state", state_dbg, 2'd0);

    // Table frames with receiver loopback
    for (int i = 0; i < 4; i++) begin
`ifdef CTRL_TX_ONESHOT_EN
      do_reset();
`endif
      rx_clear();
      start_frame(i, 1'b0);
      check_frame(i, -1, $sformatf("vec%0d", i));
      check_rx(i, $sformatf("vec%0d", i));
      if (i == 0) begin
        repeat (20) @(negedge clk);
        check_rx(i, "vec0 hold");
      end
    end

    // Busy rejection: data=FF offered at slot 4 must not disturb or queue
`ifdef CTRL_TX_ONESHOT_EN
    do_reset();
`endif
    start_frame(0, 1'b0);
    check_frame(0, 4, "reject");
    repeat (12) begin
      @(negedge clk);
      chk("reject idle busy", busy, 1'b0);
      chk("reject idle lines", {out_vref, out_data, out_conver, out_comp}, 4'h0);
      chk("reject idle done", done, 1'b0);
    end

`ifndef CTRL_TX_ONESHOT_EN
    // Back-to-back: valid held high across two words
    busy_cnt = 0;
    cnt_en = 1'b1;
    start_frame(3, 1'b1);
    vref = tbl[0].vref; data = tbl[0].data;
    conver = tbl[0].conver; comp = tbl[0].comp;
    check_frame(3, -1, "b2b1");
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(0, -1, "b2b2");
    repeat (3) @(negedge clk);
    cnt_en = 1'b0;
    chk("b2b active slots", busy_cnt, 18);
`else
    // One-shot: a second word after done is refused until reset
    do_reset();
    start_frame(1, 1'b0);
    check_frame(1, -1, "oneshot");
    vref = tbl[2].vref; data = tbl[2].data;
    conver = tbl[2].conver; comp = tbl[2].comp;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("lock ready", in_ready, 1'b0);
      chk("lock lines", {out_vref, out_data, out_conver, out_comp}, 4'h0);
      chk("lock busy", busy, 1'b0);
      chk("lock state", state_dbg, 2'd2);
    end
    in_valid = 1'b0;
    do_reset();
    start_frame(3, 1'b0);
    check_frame(3, -1, "after-lock");
    do_reset();
`endif

    // Reset mid-frame at slot 5
    start_frame(2, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst slot5 lines", {out_vref, out_data, out_conver, out_comp},
        {tbl[2].ev[5], tbl[2].ed[5], tbl[2].ec[5], tbl[2].ep[5]});
    rst = 1'b0;
    #1;
    chk("midrst lines", {out_vref, out_data, out_conver, out_comp}, 4'h0);
    chk("midrst busy", busy, 1'b0);
    @(negedge clk);
    chk("midrst no done", done, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst ready", in_ready, 1'b1);
      chk("midrst done after", done, 1'b0);
      chk("midrst lines after", {out_vref, out_data, out_conver, out_comp}, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
